mono_multi_vib: RTL and testbench

MONO_MULTI_VIB -- requirements
Module: mono_multi_vib

---
 rtl/mono_multi_vib_pkg.sv | 18 +
 rtl/mmv_channel.sv | 130 +++++++++++++
 rtl/mono_multi_vib.sv | 74 +++++++
 tb/tb_mono_multi_vib.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/mono_multi_vib_pkg.sv
// Shared definitions for the multi-channel monostable vibrator.
// Holds the trigger edge-mode encodings and the per-channel FSM state
// encoding used by mmv_channel.
package mono_multi_vib_pkg;

    typedef enum logic [1:0] {
        EDGE_FALL = 2'b00,
        EDGE_RISE = 2'b01,
        EDGE_BOTH = 2'b10,
        EDGE_OFF  = 2'b11
    } edge_mode_t;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_PULSE = 1'b1
    } mmv_state_t;

endpackage

// File: rtl/mmv_channel.sv
// One channel of the monostable vibrator: input synchronizer, edge detect,
// IDLE/PULSE one-shot FSM with down-counter, and sticky miss flag.
// Ports:
//   clk, rst            clock / async active-low reset
//   sig                 asynchronous trigger input
//   armed               high once the shared post-reset arm window has passed
//   edge_mode, retrig   global trigger edge selection and retrigger policy
//   width               pulse length in clk cycles, sampled on accepted trigger
//   miss_clr            synchronous clear of the miss flag
//   out, edge_o, miss   one-shot pulse, trigger strobe, sticky drop flag
module mmv_channel
    import mono_multi_vib_pkg::*;
#(
    parameter int CNT_W       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sig,
    input  logic             armed,
    input  logic [1:0]       edge_mode,
    input  logic             retrig,
    input  logic [CNT_W-1:0] width,
    input  logic             miss_clr,
    output logic             out,
    output logic             edge_o,
    output logic             miss
);

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [SYNC_STAGES-1:0] sync_r;
    logic                   sig_d_r;
    mmv_state_t             state_r;
    logic [CNT_W-1:0]       cnt_r;
    logic                   out_r;
    logic                   edge_r;
    logic                   miss_r;

    logic sync_s;
    logic rise_s;
    logic fall_s;
    logic trig_s;
    logic miss_set_s;

    assign sync_s = sync_r[SYNC_STAGES-1];
    assign out    = out_r;
    assign edge_o = edge_r;
    assign miss   = miss_r;

    // Edge detect and qualification by the global edge mode and arm window.
    always_comb begin
        rise_s = sync_s & ~sig_d_r;
        fall_s = ~sync_s & sig_d_r;
        case (edge_mode_t'(edge_mode))
            EDGE_FALL: trig_s = armed & fall_s;
            EDGE_RISE: trig_s = armed & rise_s;
            EDGE_BOTH: trig_s = armed & (rise_s | fall_s);
            EDGE_OFF:  trig_s = 1'b0;
            default:   trig_s = 1'b0;
        endcase
    end

    // A trigger is dropped when it cannot start a pulse (width 0) or arrives
    // mid-pulse while retriggering is disabled.
    always_comb begin
        miss_set_s = 1'b0;
        if (trig_s) begin
            if (state_r == ST_IDLE) begin
                miss_set_s = (width == CNT_ZERO);
            end else begin
                miss_set_s = ~retrig;
            end
        end else begin
            miss_set_s = 1'b0;
        end
    end

    // Synchronizer, edge strobe, miss flag and one-shot FSM with counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_r  <= {SYNC_STAGES{1'b0}};
            sig_d_r <= 1'b0;
            state_r <= ST_IDLE;
            cnt_r   <= CNT_ZERO;
            out_r   <= 1'b0;
            edge_r  <= 1'b0;
            miss_r  <= 1'b0;
        end else begin
            sync_r  <= {sync_r[SYNC_STAGES-2:0], sig};
            sig_d_r <= sync_s;
            edge_r  <= trig_s;
            // A set event on the same edge wins over the clear.
            miss_r  <= miss_set_s | (miss_r & ~miss_clr);
            case (state_r)
                ST_IDLE: begin
                    if (trig_s && (width != CNT_ZERO)) begin
                        state_r <= ST_PULSE;
                        cnt_r   <= width - CNT_ONE;
                        out_r   <= 1'b1;
                    end
                end
                ST_PULSE: begin
                    // Accepted retrigger takes priority over expiry.
                    if (trig_s && retrig) begin
                        if (width != CNT_ZERO) begin
                            cnt_r <= width - CNT_ONE;
                        end else begin
                            state_r <= ST_IDLE;
                            cnt_r   <= CNT_ZERO;
                            out_r   <= 1'b0;
                        end
                    end else if (cnt_r == CNT_ZERO) begin
                        state_r <= ST_IDLE;
                        out_r   <= 1'b0;
                    end else begin
                        cnt_r <= cnt_r - CNT_ONE;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    cnt_r   <= CNT_ZERO;
                    out_r   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/mono_multi_vib.sv
// Multi-channel retriggerable/non-retriggerable monostable vibrator.
// Holds the shared post-reset arm counter and CH independent channels.
// Ports:
//   clk, rst   clock / async active-low reset
//   sig        CH asynchronous trigger inputs
//   edge_mode  00 falling, 01 rising, 10 both, 11 disabled (global)
//   retrig     1 retriggerable, 0 non-retriggerable (global)
//   width      pulse length in clk cycles (global)
//   miss_clr   synchronous clear of all miss flags
//   out        per-channel one-shot pulse
//   edge_o     per-channel one-cycle strobe per qualified edge
//   miss       per-channel sticky dropped-trigger flag
module mono_multi_vib
    import mono_multi_vib_pkg::*;
#(
    parameter int CH          = 4,
    parameter int CNT_W       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [CH-1:0]    sig,
    input  logic [1:0]       edge_mode,
    input  logic             retrig,
    input  logic [CNT_W-1:0] width,
    input  logic             miss_clr,
    output logic [CH-1:0]    out,
    output logic [CH-1:0]    edge_o,
    output logic [CH-1:0]    miss
);

    // Triggers stay blocked for the first SYNC_STAGES+1 edges after reset so
    // the reset-cleared sync chain filling with a static-high input is not
    // mistaken for a rising edge.
    localparam int                ARM_W    = $clog2(SYNC_STAGES + 2);
    localparam logic [ARM_W-1:0] ARM_LAST = ARM_W'(SYNC_STAGES + 1);
    localparam logic [ARM_W-1:0] ARM_ONE  = {{(ARM_W-1){1'b0}}, 1'b1};

    logic [ARM_W-1:0] arm_cnt_r;
    logic             armed_s;

    assign armed_s = (arm_cnt_r == ARM_LAST);

    // Shared arm counter, saturating once the arm window has elapsed.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            arm_cnt_r <= {ARM_W{1'b0}};
        end else if (!armed_s) begin
            arm_cnt_r <= arm_cnt_r + ARM_ONE;
        end else begin
            arm_cnt_r <= arm_cnt_r;
        end
    end

    for (genvar i = 0; i < CH; i++) begin : g_ch
        mmv_channel #(
            .CNT_W       (CNT_W),
            .SYNC_STAGES (SYNC_STAGES)
        ) u_ch (
            .clk       (clk),
            .rst       (rst),
            .sig       (sig[i]),
            .armed     (armed_s),
            .edge_mode (edge_mode),
            .retrig    (retrig),
            .width     (width),
            .miss_clr  (miss_clr),
            .out       (out[i]),
            .edge_o    (edge_o[i]),
            .miss      (miss[i])
        );
    end

endmodule

// File: tb/tb_mono_multi_vib.sv
// Scoreboard bench for mono_multi_vib (defaults CH=4, CNT_W=8, SYNC_STAGES=2).
// Each scenario pushes per-cycle stimulus and the expected outputs derived
// from the required timing; the runner drives, then pops and compares.
module tb_mono_multi_vib;
    import mono_multi_vib_pkg::*;

    localparam int CH    = 4;
    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic [CH-1:0]    sig;
    logic [1:0]       edge_mode;
    logic             retrig;
    logic [CNT_W-1:0] width;
    logic             miss_clr;
    logic [CH-1:0]    out;
    logic [CH-1:0]    edge_o;
    logic [CH-1:0]    miss;

    typedef struct packed {
        logic [CH-1:0]    sig;
        logic [CNT_W-1:0] width;
        logic             miss_clr;
    } stim_t;

    typedef struct packed {
        logic [CH-1:0] out;
        logic [CH-1:0] edg;
        logic [CH-1:0] miss;
    } exp_t;

    stim_t stim_q[$];
    exp_t  exp_q[$];
    int    checks   = 0;
    int    failures = 0;

    mono_multi_vib dut (
        .clk       (clk),
        .rst       (rst),
        .sig       (sig),
        .edge_mode (edge_mode),
        .retrig    (retrig),
        .width     (width),
        .miss_clr  (miss_clr),
        .out       (out),
        .edge_o    (edge_o),
        .miss      (miss)
    );

    // Free-running 10-unit clock.
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp_v);
        end
    endtask

    // Build stimulus and expectations for scenario scn over n cycles.
    // Cycle j's input is sampled at edge j; expectations describe the
    // outputs after edge j (trigger registered SYNC_STAGES edges later).
    task automatic gen(input int scn, input int n);
        stim_t s;
        exp_t  e;
        for (int j = 0; j < n; j++) begin
            s = '0;
            e = '0;
            case (scn)
                1: begin // single falling edge on ch0, width changed mid-pulse
                    s.width = (j <= 12) ? 8'd5 : 8'd9;
                    s.sig   = (j < 10) ? 4'b0001 : 4'b0000;
                    e.edg   = (j == 12) ? 4'b0001 : 4'b0000;
                    e.out   = (j >= 12 && j <= 16) ? 4'b0001 : 4'b0000;
                end
                2, 3: begin // second fall 2 cycles into a 4-cycle pulse
                    s.width = 8'd4;
                    s.sig   = (j < 4 || j == 5) ? 4'b0001 : 4'b0000;
                    e.edg   = (j == 6 || j == 8) ? 4'b0001 : 4'b0000;
                    if (scn == 2) begin
                        e.out = (j >= 6 && j <= 11) ? 4'b0001 : 4'b0000;
                    end else begin
                        e.out      = (j >= 6 && j <= 9) ? 4'b0001 : 4'b0000;
                        e.miss     = (j >= 8 && j < 13) ? 4'b0001 : 4'b0000;
                        s.miss_clr = (j == 13);
                    end
                end
                4, 5: begin // 10-cycle high pulse, both edges / disabled
                    s.width = 8'd3;
                    s.sig   = (j >= 2 && j <= 11) ? 4'b0001 : 4'b0000;
                    if (scn == 4) begin
                        e.edg = (j == 4 || j == 14) ? 4'b0001 : 4'b0000;
                        e.out = ((j >= 4 && j <= 6) || (j >= 14 && j <= 16)) ? 4'b0001 : 4'b0000;
                    end
                end
                6: begin // width 0 trigger on ch1, set wins over same-edge clear
                    s.width    = 8'd0;
                    s.sig      = (j >= 2) ? 4'b0010 : 4'b0000;
                    s.miss_clr = (j == 4 || j == 8);
                    e.edg      = (j == 4) ? 4'b0010 : 4'b0000;
                    e.miss     = (j >= 4 && j < 8) ? 4'b0010 : 4'b0000;
                end
                7: begin // all channels triggered on the same edge
                    s.width = 8'd2;
                    s.sig   = (j >= 4) ? 4'b1111 : 4'b0000;
                    e.edg   = (j == 6) ? 4'b1111 : 4'b0000;
                    e.out   = (j == 6 || j == 7) ? 4'b1111 : 4'b0000;
                end
                8: begin // static-high inputs after reset release
                    s.width = 8'd2;
                    s.sig   = 4'b1111;
                end
                9: begin // long pulse, interrupted by reset afterwards
                    s.width = 8'd8;
                    s.sig   = (j >= 2) ? 4'b1111 : 4'b0000;
                    e.edg   = (j == 4) ? 4'b1111 : 4'b0000;
                    e.out   = (j >= 4) ? 4'b1111 : 4'b0000;
                end
                default: begin
                    s = '0;
                    e = '0;
                end
            endcase
            stim_q.push_back(s);
            exp_q.push_back(e);
        end
    endtask

    // Drain the scoreboard: drive one stimulus per cycle, compare after the edge.
    task automatic run_q(input int scn);
        stim_t s;
        exp_t  e;
        int    cyc = 0;
        while (stim_q.size() > 0) begin
            s        = stim_q.pop_front();
            sig      = s.sig;
            width    = s.width;
            miss_clr = s.miss_clr;
            @(posedge clk);
            @(negedge clk);
            e = exp_q.pop_front();
            check_eq($sformatf("s%0d c%0d out", scn, cyc), 32'(out), 32'(e.out));
            check_eq($sformatf("s%0d c%0d edge_o", scn, cyc), 32'(edge_o), 32'(e.edg));
            check_eq($sformatf("s%0d c%0d miss", scn, cyc), 32'(miss), 32'(e.miss));
            cyc++;
        end
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b0;
        #1;
        check_eq({tag, " out"}, 32'(out), 32'd0);
        check_eq({tag, " edge_o"}, 32'(edge_o), 32'd0);
        check_eq({tag, " miss"}, 32'(miss), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    // Main sequence of scenarios.
    initial begin
        rst       = 1'b1;
        sig       = 4'b0001;
        edge_mode = EDGE_FALL;
        retrig    = 1'b0;
        width     = 8'd5;
        miss_clr  = 1'b0;
        #2;
        do_reset("rst0");

        gen(1, 22); run_q(1);

        retrig = 1'b1;
        gen(2, 16); run_q(2);
        retrig = 1'b0;
        gen(3, 16); run_q(3);

        edge_mode = EDGE_BOTH;
        gen(4, 20); run_q(4);
        edge_mode = EDGE_OFF;
        gen(5, 20); run_q(5);

        edge_mode = EDGE_RISE;
        gen(6, 10); run_q(6);
        gen(7, 12); run_q(7);

        do_reset("rst1");
        gen(8, 10); run_q(8);

        gen(9, 7); run_q(9);
        do_reset("rst_mid");
        gen(8, 12); run_q(10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
